// File: rtl/sram_req_ctrl_pkg.sv
// Shared constants for the SRAM request controller: FSM encoding and width helpers.
package sram_req_ctrl_pkg;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] CLEAR = 1'b1;

   function automatic int addr_width(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

   function automatic int be_width(input int data_width);
      return (data_width + 7) / 8;
   endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small response FIFO for read data; output comes straight from storage, so a push
// is never visible on data_o in the same cycle.
module sram_rsp_fifo #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 3,
   localparam int CW        = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [CW-1:0]         count,
   output logic                  empty,
   output logic                  full
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;
   logic                  do_push;
   logic                  do_pop;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign data_o  = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= bump(wr_ptr);
         if (do_pop)  rd_ptr <= bump(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Payload storage needs no reset; count/pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/sram_req_ctrl.sv
// Initiator-side controller for the single-port SRAM: request stream to macro port,
// credit-checked reads into a response FIFO, and a hardware zero-fill sweep.
module sram_req_ctrl
   import sram_req_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_WORDS  = 1024,
   parameter int RSP_DEPTH  = 3,
   localparam int AW        = addr_width(NUM_WORDS),
   localparam int BW        = be_width(DATA_WIDTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [AW-1:0]         req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   input  logic [BW-1:0]         req_be_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   input  logic                  clear_i,
   output logic                  busy_o,
   output logic                  clear_done_o,
   output logic                  sram_req_o,
   output logic                  sram_we_o,
   output logic [AW-1:0]         sram_addr_o,
   output logic [DATA_WIDTH-1:0] sram_wdata_o,
   output logic [BW-1:0]         sram_be_o,
   input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

   localparam int            CW        = $clog2(RSP_DEPTH + 1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_WORDS - 1);

   logic [0:0]    state;
   logic [AW-1:0] sweep_addr;
   logic          rd_inflight;
   logic          clear_done;
   logic [CW-1:0] fifo_count;
   logic          fifo_empty;
   logic          fifo_full;
   logic          idle;
   logic          credit_ok;
   logic          issue_rd;
   logic          pop;

   assign idle = (state == IDLE);

   // Credits come only from flops, so rsp_ready_i never reaches req_ready_o.
   assign credit_ok   = !fifo_full &&
                        ((int'(fifo_count) + int'(rd_inflight)) < RSP_DEPTH);
   assign req_ready_o = !rst_i && idle && (req_we_i || credit_ok);
   assign issue_rd    = idle && req_valid_i && req_ready_o && !req_we_i;

   assign rsp_valid_o  = !fifo_empty;
   assign pop          = rsp_valid_o && rsp_ready_i;
   assign busy_o       = (state == CLEAR);
   assign clear_done_o = clear_done;

   always_comb begin
      if (state == CLEAR) begin
         sram_req_o   = 1'b1;
         sram_we_o    = 1'b1;
         sram_addr_o  = sweep_addr;
         sram_wdata_o = '0;
         sram_be_o    = '1;
      end else begin
         sram_req_o   = req_valid_i && req_ready_o;
         sram_we_o    = req_we_i;
         sram_addr_o  = req_addr_i;
         sram_wdata_o = req_wdata_i;
         sram_be_o    = req_be_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         sweep_addr  <= '0;
         rd_inflight <= 1'b0;
         clear_done  <= 1'b0;
      end else begin
         clear_done  <= 1'b0;
         rd_inflight <= issue_rd;
         case (state)
            IDLE: begin
               if (clear_i) begin
                  state      <= CLEAR;
                  sweep_addr <= '0;
               end
            end
            CLEAR: begin
               // Compare against the last word so non-power-of-two depths stop in range.
               if (sweep_addr == LAST_ADDR) begin
                  state      <= IDLE;
                  sweep_addr <= '0;
                  clear_done <= 1'b1;
               end else begin
                  sweep_addr <= sweep_addr + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Data from last cycle's read lands unconditionally; the credit check reserved the slot.
   sram_rsp_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (rd_inflight),
      .pop   (pop),
      .wdata (sram_rdata_i),
      .data_o(rsp_rdata_o),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

endmodule
